// File: rtl/crc8_frame_checker.sv
// CRC-8 (poly 0x07, MSB-first, no reflection, no final XOR) frame checker with length checking.
// Optional feature: define CRC8_CHK_ERRCNT_EN to add a saturating bad-frame counter output err_cnt.
`timescale 1ns/1ps

module crc8_frame_checker #(
    parameter logic [7:0] CRC_INIT  = 8'h00,
    parameter int         MAX_BYTES = 255
) (
    input  logic       CP,
    input  logic       CD,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    input  logic       st_ready,
    output logic       st_valid,
    output logic       st_ok,
    output logic       st_len_err
`ifdef CRC8_CHK_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);

    // Whole-byte CRC-8 update: all eight polynomial steps unrolled into one cycle.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] crc_q, crc_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;
    logic       in_ready_q, in_ready_d;
    logic       st_valid_q, st_valid_d;
    logic       st_ok_q, st_ok_d;
    logic       st_len_err_q, st_len_err_d;

    logic       accept_s;
    logic       first_s;
    logic [7:0] crc_base_s;
    logic [7:0] crc_upd_s;
    logic [7:0] cnt_base_s;
    logic [7:0] cnt_upd_s;
    logic       ovf_base_s;
    logic       ovf_upd_s;
    logic       len_err_s;

    // Per-byte datapath: CRC, saturating count and overflow flag, restarted on a frame's first byte.
    always_comb begin
        accept_s   = in_valid && in_ready_q;
        first_s    = (state_q == IDLE);
        crc_base_s = first_s ? CRC_INIT : crc_q;
        cnt_base_s = first_s ? 8'd0 : cnt_q;
        ovf_base_s = first_s ? 1'b0 : ovf_q;
        crc_upd_s  = crc8_byte(crc_base_s, in_data);
        // ovf remembers a byte arrived past the 255 saturation point, so 256+ stays illegal.
        if (cnt_base_s == 8'd255) begin
            cnt_upd_s = 8'd255;
            ovf_upd_s = 1'b1;
        end else begin
            cnt_upd_s = cnt_base_s + 8'd1;
            ovf_upd_s = ovf_base_s;
        end
        len_err_s = ovf_upd_s || (cnt_upd_s < 8'd2) || (cnt_upd_s > MAX_LEN);
    end

    // Frame FSM next-state, datapath commit and status capture.
    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        st_valid_d   = st_valid_q;
        st_ok_d      = st_ok_q;
        st_len_err_d = st_len_err_q;
        case (state_q)
            IDLE, RUN: begin
                if (accept_s) begin
                    crc_d = crc_upd_s;
                    cnt_d = cnt_upd_s;
                    ovf_d = ovf_upd_s;
                    if (in_last) begin
                        state_d      = REPORT;
                        st_valid_d   = 1'b1;
                        st_len_err_d = len_err_s;
                        st_ok_d      = !len_err_s && (crc_upd_s == 8'h00);
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            REPORT: begin
                if (st_ready) begin
                    state_d      = IDLE;
                    st_valid_d   = 1'b0;
                    st_ok_d      = 1'b0;
                    st_len_err_d = 1'b0;
                end else begin
                    state_d = REPORT;
                end
            end
            default: begin
                state_d      = IDLE;
                st_valid_d   = 1'b0;
                st_ok_d      = 1'b0;
                st_len_err_d = 1'b0;
            end
        endcase
        in_ready_d = (state_d != REPORT);
    end

    // State and status registers.
    always_ff @(posedge CP or posedge CD) begin
        if (CD) begin
            state_q      <= IDLE;
            crc_q        <= CRC_INIT;
            cnt_q        <= 8'd0;
            ovf_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            st_valid_q   <= 1'b0;
            st_ok_q      <= 1'b0;
            st_len_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            in_ready_q   <= in_ready_d;
            st_valid_q   <= st_valid_d;
            st_ok_q      <= st_ok_d;
            st_len_err_q <= st_len_err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign st_valid   = st_valid_q;
    assign st_ok      = st_ok_q;
    assign st_len_err = st_len_err_q;

`ifdef CRC8_CHK_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Bad-frame counter: bumps on each consumed status that was not OK, saturating at 255.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((state_q == REPORT) && st_ready && !st_ok_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Bad-frame counter register.
    always_ff @(posedge CP or posedge CD) begin
        if (CD) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc8_frame_checker.sv
// Directed, table-driven bench for crc8_frame_checker (MAX_BYTES=255 and MAX_BYTES=4 instances).
`timescale 1ns/1ps

module tb_crc8_frame_checker;

    logic       CP;
    logic       CD;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       st_ready;
    logic       in_ready, st_valid, st_ok, st_len_err;
    logic       in_ready4, st_valid4, st_ok4, st_len_err4;
`ifdef CRC8_CHK_ERRCNT_EN
    logic [7:0] err_cnt, err_cnt4;
    int         exp_err;
`endif

    int checks;
    int errors;

    crc8_frame_checker dut (
        .CP(CP), .CD(CD),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .st_ready(st_ready), .st_valid(st_valid), .st_ok(st_ok), .st_len_err(st_len_err)
`ifdef CRC8_CHK_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    crc8_frame_checker #(.MAX_BYTES(4)) dut4 (
        .CP(CP), .CD(CD),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready4),
        .st_ready(st_ready), .st_valid(st_valid4), .st_ok(st_ok4), .st_len_err(st_len_err4)
`ifdef CRC8_CHK_ERRCNT_EN
        , .err_cnt(err_cnt4)
`endif
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    typedef struct {
        logic [9:0][7:0] b;   // b[9] is the first byte; bytes past the tenth are 8'h00
        int              n;
        logic            ok;
        logic            le;
        logic            ok4;
        logic            le4;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input int idx, input int i);
        if (i < 10) return vecs[idx].b[9-i];
        return 8'h00;
    endfunction

    task automatic send_byte(input logic [7:0] d, input logic last, input bit gaps);
        int budget;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge CP);
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
            end
        end
        @(negedge CP);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 10;
        while (!in_ready && budget > 0) begin
            @(negedge CP);
            budget--;
        end
        if (budget == 0) chk("accept_timeout", 32'd0, 32'd1);
        if (last) chk("st_valid_early", {31'd0, st_valid}, 32'd0);
        @(posedge CP);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input int idx, input bit gaps, input int stall);
        logic ok_hold;
        st_ready = (stall == 0);
        for (int i = 0; i < vecs[idx].n; i++) begin
            send_byte(byte_of(idx, i), (i == vecs[idx].n - 1), gaps);
        end
        chk($sformatf("v%0d_st_valid", idx), {31'd0, st_valid}, 32'd1);
        chk($sformatf("v%0d_in_ready_rep", idx), {31'd0, in_ready}, 32'd0);
        chk($sformatf("v%0d_st_ok", idx), {31'd0, st_ok}, {31'd0, vecs[idx].ok});
        chk($sformatf("v%0d_st_len_err", idx), {31'd0, st_len_err}, {31'd0, vecs[idx].le});
        chk($sformatf("v%0d_st_ok4", idx), {31'd0, st_ok4}, {31'd0, vecs[idx].ok4});
        chk($sformatf("v%0d_st_len_err4", idx), {31'd0, st_len_err4}, {31'd0, vecs[idx].le4});
        ok_hold = vecs[idx].ok;
        for (int c = 0; c < stall; c++) begin
            @(negedge CP);
            chk($sformatf("v%0d_stall_valid", idx), {31'd0, st_valid}, 32'd1);
            chk($sformatf("v%0d_stall_ok", idx), {31'd0, st_ok}, {31'd0, ok_hold});
            chk($sformatf("v%0d_stall_len", idx), {31'd0, st_len_err}, {31'd0, vecs[idx].le});
            chk($sformatf("v%0d_stall_ready", idx), {31'd0, in_ready}, 32'd0);
        end
        if (stall > 0) begin
            @(negedge CP);
            st_ready = 1'b1;
        end
        @(posedge CP);
        #1;
        chk($sformatf("v%0d_in_ready_after", idx), {31'd0, in_ready}, 32'd1);
        chk($sformatf("v%0d_st_valid_after", idx), {31'd0, st_valid}, 32'd0);
`ifdef CRC8_CHK_ERRCNT_EN
        if (!vecs[idx].ok && exp_err < 255) exp_err++;
        chk($sformatf("v%0d_err_cnt", idx), {24'd0, err_cnt}, exp_err);
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        errors   = 0;
`ifdef CRC8_CHK_ERRCNT_EN
        exp_err  = 0;
`endif
        vecs[0]  = '{b: {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4},
                     n: 10, ok: 1'b1, le: 1'b0, ok4: 1'b0, le4: 1'b1};
        vecs[1]  = '{b: {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF5},
                     n: 10, ok: 1'b0, le: 1'b0, ok4: 1'b0, le4: 1'b1};
        vecs[2]  = '{b: {8'h00, 72'h0},        n: 1,   ok: 1'b0, le: 1'b1, ok4: 1'b0, le4: 1'b1};
        vecs[3]  = '{b: {8'h00, 8'h00, 64'h0}, n: 2,   ok: 1'b1, le: 1'b0, ok4: 1'b1, le4: 1'b0};
        vecs[4]  = '{b: {8'h01, 8'h07, 64'h0}, n: 2,   ok: 1'b1, le: 1'b0, ok4: 1'b1, le4: 1'b0};
        vecs[5]  = '{b: {8'h01, 8'h08, 64'h0}, n: 2,   ok: 1'b0, le: 1'b0, ok4: 1'b0, le4: 1'b0};
        vecs[6]  = '{b: {8'h80, 8'h89, 64'h0}, n: 2,   ok: 1'b1, le: 1'b0, ok4: 1'b1, le4: 1'b0};
        vecs[7]  = '{b: 80'h0,                 n: 4,   ok: 1'b1, le: 1'b0, ok4: 1'b1, le4: 1'b0};
        vecs[8]  = '{b: 80'h0,                 n: 5,   ok: 1'b1, le: 1'b0, ok4: 1'b0, le4: 1'b1};
        vecs[9]  = '{b: 80'h0,                 n: 6,   ok: 1'b1, le: 1'b0, ok4: 1'b0, le4: 1'b1};
        vecs[10] = '{b: 80'h0,                 n: 255, ok: 1'b1, le: 1'b0, ok4: 1'b0, le4: 1'b1};
        vecs[11] = '{b: 80'h0,                 n: 256, ok: 1'b0, le: 1'b1, ok4: 1'b0, le4: 1'b1};
        vecs[12] = '{b: {8'h80, 72'h0},        n: 1,   ok: 1'b0, le: 1'b1, ok4: 1'b0, le4: 1'b1};

        CD       = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        st_ready = 1'b1;
        #1;
        chk("rst_st_valid", {31'd0, st_valid}, 32'd0);
        chk("rst_st_ok", {31'd0, st_ok}, 32'd0);
        chk("rst_st_len_err", {31'd0, st_len_err}, 32'd0);
        @(negedge CP);
        @(negedge CP);
        CD = 1'b0;
        @(negedge CP);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef CRC8_CHK_ERRCNT_EN
        chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

        for (int v = 0; v < NV; v++) begin
            run_frame(v, 1'b0, 0);
        end

        // Random in_valid gaps with garbage on in_data/in_last while idle.
        run_frame(0, 1'b1, 0);
        run_frame(1, 1'b1, 0);
        run_frame(4, 1'b1, 0);

        // Status back-pressure for five cycles.
        run_frame(0, 1'b0, 5);
        run_frame(5, 1'b0, 5);

        // Reset after four bytes of a frame.
        for (int i = 0; i < 4; i++) send_byte(byte_of(0, i), 1'b0, 1'b0);
        @(negedge CP);
        CD = 1'b1;
        #1;
        chk("midrst_st_valid", {31'd0, st_valid}, 32'd0);
        @(negedge CP);
        CD = 1'b0;
`ifdef CRC8_CHK_ERRCNT_EN
        exp_err = 0;
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge CP);
            chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("midrst_no_status", {31'd0, st_valid}, 32'd0);
        end
        run_frame(0, 1'b0, 0);

        // Reset while a status is pending.
        st_ready = 1'b0;
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h00, 1'b1, 1'b0);
        chk("reprst_pending", {31'd0, st_valid}, 32'd1);
        @(negedge CP);
        CD = 1'b1;
        #1;
        chk("reprst_st_valid", {31'd0, st_valid}, 32'd0);
        chk("reprst_st_ok", {31'd0, st_ok}, 32'd0);
        @(negedge CP);
        CD = 1'b0;
        st_ready = 1'b1;
`ifdef CRC8_CHK_ERRCNT_EN
        exp_err = 0;
`endif
        for (int c = 0; c < 3; c++) begin
            @(negedge CP);
            chk("reprst_in_ready", {31'd0, in_ready}, 32'd1);
            chk("reprst_no_status", {31'd0, st_valid}, 32'd0);
        end
        run_frame(6, 1'b0, 0);

`ifdef CRC8_CHK_ERRCNT_EN
        // 300 bad frames drive the counter into saturation.
        for (int f = 0; f < 300; f++) begin
            send_byte(8'h00, 1'b1, 1'b0);
        end
        @(negedge CP);
        @(negedge CP);
        chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc8_frame_checker.md
CRC8_FRAME_CHECKER -- requirements
Module: crc8_frame_checker

Interface
REQ-001: The module SHALL provide parameter CRC_INIT, default 8'h00, CRC register seed loaded at the start of every frame.
REQ-002: The module SHALL provide parameter MAX_BYTES, default 255, the maximum accepted frame length in bytes, including the trailing CRC byte; legal range is 2..255.
REQ-003: The module SHALL have port CP, input, 1 bit, the single clock, rising-edge active.
REQ-004: The module SHALL have port CD, input, 1 bit, the reset, asynchronous and active-high.
REQ-005: The module SHALL have ports in_valid (input, 1 bit), in_data (input, 8 bits) and in_last (input, 1 bit) carrying the byte stream, with in_last marking the final byte, which is the CRC byte.
REQ-006: The module SHALL have port in_ready, output, 1 bit, byte acceptance.
REQ-007: The module SHALL have port st_valid, output, 1 bit, frame status available.
REQ-008: The module SHALL have port st_ok, output, 1 bit, meaning CRC residue is zero and length is legal.
REQ-009: The module SHALL have port st_len_err, output, 1 bit, meaning frame length is below 2 or above MAX_BYTES.
REQ-010: The module SHALL have port st_ready, input, 1 bit, status consumed.

Function
REQ-011: The module SHALL accept a byte only on a CP edge where in_valid and in_ready are both high.
REQ-012: The CRC SHALL be CRC-8 with polynomial x^8+x^2+x+1 (0x07), MSB-first, no reflection and no final XOR, with next = f(crc XOR byte) and all eight bit steps computed in one cycle.
REQ-013: The CRC update SHALL cover every byte of the frame, including the CRC byte; a residue of 8'h00 after the last byte SHALL mean a CRC pass.
REQ-014: The FSM SHALL have states IDLE, RUN and REPORT: IDLE goes to RUN on an accepted byte with in_last=0; IDLE or RUN goes to REPORT on an accepted byte with in_last=1; REPORT goes to IDLE on st_valid and st_ready.
REQ-015: The first accepted byte in IDLE SHALL compute from CRC_INIT regardless of the stale CRC register contents.
REQ-016: in_ready SHALL be 1 in IDLE and RUN and 0 in REPORT.
REQ-017: st_valid SHALL be 1 only in REPORT, asserting on the cycle after the in_last byte is accepted (latency 1).
REQ-018: st_ok, st_len_err and st_valid SHALL be registered and SHALL hold stable while st_valid=1 and st_ready=0.
REQ-019: A byte counter SHALL count accepted bytes of the current frame, saturating at 255 with no wrap.
REQ-020: st_len_err SHALL be 1 when the count including the last byte is below 2 or above MAX_BYTES; st_ok SHALL then be 0 regardless of the residue.
REQ-021: When a frame exceeds MAX_BYTES, the module SHALL keep accepting and discarding bytes until in_last, then report st_len_err=1.
REQ-022: in_ready SHALL return to 1 on the cycle after the status handshake; back-to-back frames SHALL incur exactly one idle in_ready cycle for the status handshake.
REQ-023: in_data and in_last SHALL be ignored when in_valid=0, and no state SHALL change.

Reset
REQ-024: Asserting CD SHALL immediately set state=IDLE, crc=CRC_INIT, count=0, st_valid=0, st_ok=0 and st_len_err=0, with in_ready=1 once CD is released.
REQ-025: Reset asserted mid-frame or in REPORT SHALL discard the partial frame or pending status, with no status emitted.

Configuration
REQ-026: With CRC8_CHK_ERRCNT_EN defined, the module SHALL add output err_cnt (8 bits, reset 0), incremented at each status handshake where st_ok=0 and saturating at 255.
REQ-027: Without CRC8_CHK_ERRCNT_EN, the err_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028: Bytes 31 32 33 34 35 36 37 38 39 F4 with last on F4 and st_ready=1 -> st_valid=1 one cycle later, st_ok=1, st_len_err=0.
REQ-029: The same frame with the CRC byte F5 -> st_ok=0, st_len_err=0, and err_cnt goes 0->1 when CRC8_CHK_ERRCNT_EN is defined.
REQ-030: A single byte 00 with last -> st_len_err=1, st_ok=0; with MAX_BYTES=4, a 6-byte valid-CRC frame -> st_len_err=1, st_ok=0.
REQ-031: Holding st_ready=0 for 5 cycles after status -> in_ready=0 and status stable throughout, then in_ready=1 the cycle after st_ready=1.
REQ-032: Asserting CD after 4 bytes of a frame -> in_ready=1, no status emitted, and the next "123456789"+F4 frame reports st_ok=1.
REQ-033: Randomized in_valid gaps on the REQ-028 frame -> same result; with CRC8_CHK_ERRCNT_EN, 300 bad frames -> err_cnt=255.
